// File: rtl/wb_regfile.sv
// Write-back stage: selects the write-back value, commits it to the register
// file, latches the Z/N flags and serves two bypassed decode read ports.
module wb_regfile #(
  parameter int unsigned NUM_REGS       = 64,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned ZERO_HARDWIRED = 0,
  parameter int unsigned CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              regWriteWB,
  input  logic              memToRegWB,
  input  logic              zeroWB,
  input  logic              negWB,
  input  logic              flagWriteWB,
  input  logic [DATA_W-1:0] memDataOutWB,
  input  logic [DATA_W-1:0] AluResultsWB,
  input  logic [5:0]        rdWB,
  input  logic [5:0]        rsID,
  input  logic [5:0]        rtID,
  output logic [DATA_W-1:0] rsData,
  output logic [DATA_W-1:0] rtData,
  output logic              zeroFlag,
  output logic              negFlag,
  output logic [DATA_W-1:0] wbData,
  output logic [CNT_W-1:0]  wbCount
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic              zero_q;
  logic              neg_q;
  logic [CNT_W-1:0]  count_q;
  logic              wr_en;

  // Write-back mux and effective commit enable. regWriteWB gates first so an
  // X on rdWB cannot leak into the enable while no write is requested.
  always_comb begin
    wbData = memToRegWB ? memDataOutWB : AluResultsWB;
    wr_en  = regWriteWB;
    if (regWriteWB && (ZERO_HARDWIRED != 0) && (rdWB == 6'd0)) begin
      wr_en = 1'b0;
    end
  end

  // Register file commit; reset clears every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[rdWB] <= wbData;
    end
  end

  // Z/N flag register, updated independently of register writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
    end else if (flagWriteWB) begin
      zero_q <= zeroWB;
      neg_q  <= negWB;
    end
  end

  // Retired-write counter; wraps silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (wr_en) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  // Read ports with write-first bypass; hardwired r0 overrides the bypass.
  always_comb begin
    rsData = regs_q[rsID];
    rtData = regs_q[rtID];
    if (wr_en && (rsID == rdWB)) rsData = wbData;
    if (wr_en && (rtID == rdWB)) rtData = wbData;
    if ((ZERO_HARDWIRED != 0) && (rsID == 6'd0)) rsData = '0;
    if ((ZERO_HARDWIRED != 0) && (rtID == 6'd0)) rtData = '0;
  end

  // Flag outputs bypass the pending update in the same cycle.
  always_comb begin
    zeroFlag = flagWriteWB ? zeroWB : zero_q;
    negFlag  = flagWriteWB ? negWB  : neg_q;
    wbCount  = count_q;
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: a default instance plus one with hardwired
// r0 and a 4-bit counter, both driven by the same stimulus.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        regWriteWB, memToRegWB, zeroWB, negWB, flagWriteWB;
  logic [31:0] memDataOutWB, AluResultsWB;
  logic [5:0]  rdWB, rsID, rtID;

  logic [31:0] rs_a, rt_a, wb_a, rs_b, rt_b, wb_b;
  logic        z_a, n_a, z_b, n_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk(clk), .rst_n(rst_n), .regWriteWB(regWriteWB), .memToRegWB(memToRegWB),
    .zeroWB(zeroWB), .negWB(negWB), .flagWriteWB(flagWriteWB),
    .memDataOutWB(memDataOutWB), .AluResultsWB(AluResultsWB), .rdWB(rdWB),
    .rsID(rsID), .rtID(rtID), .rsData(rs_a), .rtData(rt_a), .zeroFlag(z_a),
    .negFlag(n_a), .wbData(wb_a), .wbCount(cnt_a)
  );

  wb_regfile #(.ZERO_HARDWIRED(1), .CNT_W(4)) dut_hz (
    .clk(clk), .rst_n(rst_n), .regWriteWB(regWriteWB), .memToRegWB(memToRegWB),
    .zeroWB(zeroWB), .negWB(negWB), .flagWriteWB(flagWriteWB),
    .memDataOutWB(memDataOutWB), .AluResultsWB(AluResultsWB), .rdWB(rdWB),
    .rsID(rsID), .rtID(rtID), .rsData(rs_b), .rtData(rt_b), .zeroFlag(z_b),
    .negFlag(n_b), .wbData(wb_b), .wbCount(cnt_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge, leaving 1 time unit of margin.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    regWriteWB = 0; memToRegWB = 0; zeroWB = 0; negWB = 0; flagWriteWB = 0;
    memDataOutWB = '0; AluResultsWB = '0; rdWB = '0; rsID = 6'd7; rtID = 6'd12;
    #2;
    check_eq("reset_rs", rs_a, 32'h0);
    check_eq("reset_flags", {30'b0, z_a, n_a}, 32'h0);
    check_eq("reset_cnt", {16'b0, cnt_a}, 32'h0);
    step();
    rst_n = 1'b1;

    // ALU write-back to r7
    memToRegWB = 0; AluResultsWB = 32'hA5; memDataOutWB = 32'h1111_1111;
    rdWB = 6'd7; regWriteWB = 1; rsID = 6'd7;
    #1 check_eq("alu_wbdata", wb_a, 32'hA5);
    step();
    regWriteWB = 0;
    #1 check_eq("alu_rs", rs_a, 32'hA5);
    check_eq("alu_cnt", {16'b0, cnt_a}, 32'd1);

    // Load write-back to r12, both ports bypassed before the edge
    memToRegWB = 1; memDataOutWB = 32'hDEAD_BEEF; rdWB = 6'd12; regWriteWB = 1;
    rsID = 6'd12; rtID = 6'd12;
    #1 check_eq("ld_byp_rs", rs_a, 32'hDEAD_BEEF);
    check_eq("ld_byp_rt", rt_a, 32'hDEAD_BEEF);
    step();
    regWriteWB = 0; memToRegWB = 0; AluResultsWB = 32'h0;
    #1 check_eq("ld_rs", rs_a, 32'hDEAD_BEEF);
    check_eq("ld_rt", rt_a, 32'hDEAD_BEEF);
    check_eq("ld_cnt", {16'b0, cnt_a}, 32'd2);

    // Disabled write keeps r7 and the count; wbData still follows the mux
    regWriteWB = 0; rdWB = 6'd7; AluResultsWB = 32'hFFFF_FFFF; rsID = 6'd7;
    #1 check_eq("dis_wbdata", wb_a, 32'hFFFF_FFFF);
    check_eq("dis_byp_rs", rs_a, 32'hA5);
    step();
    check_eq("dis_rs", rs_a, 32'hA5);
    check_eq("dis_cnt", {16'b0, cnt_a}, 32'd2);

    // X on write controls while disabled must not corrupt state
    rdWB = 'x; AluResultsWB = 'x; memDataOutWB = 'x;
    step();
    rdWB = 6'd0; AluResultsWB = 32'h0; memDataOutWB = 32'h0;
    #1 check_eq("x_rs", rs_a, 32'hA5);
    check_eq("x_cnt", {16'b0, cnt_a}, 32'd2);

    // Flags: same-cycle bypass, then hold
    flagWriteWB = 1; zeroWB = 1; negWB = 0;
    #1 check_eq("flag_byp", {30'b0, z_a, n_a}, 32'b10);
    step();
    flagWriteWB = 0; zeroWB = 0; negWB = 1;
    #1 check_eq("flag_hold", {30'b0, z_a, n_a}, 32'b10);
    step();
    check_eq("flag_hold2", {30'b0, z_a, n_a}, 32'b10);
    flagWriteWB = 1; zeroWB = 0; negWB = 1;
    step();
    flagWriteWB = 0; zeroWB = 1; negWB = 0;
    #1 check_eq("flag_neg", {30'b0, z_a, n_a}, 32'b01);

    // Write 0x55 to r0: default instance stores it, hardwired one discards it
    memToRegWB = 0; AluResultsWB = 32'h55; rdWB = 6'd0; regWriteWB = 1;
    rsID = 6'd0; rtID = 6'd0;
    #1 check_eq("r0_byp_def", rs_a, 32'h55);
    check_eq("r0_byp_hz", rs_b, 32'h0);
    check_eq("r0_byp_hz_rt", rt_b, 32'h0);
    step();
    regWriteWB = 0;
    #1 check_eq("r0_def", rs_a, 32'h55);
    check_eq("r0_hz", rs_b, 32'h0);
    check_eq("r0_cnt_def", {16'b0, cnt_a}, 32'd3);
    check_eq("r0_cnt_hz", {28'b0, cnt_b}, 32'd2);

    // 14 more writes: 4-bit counter reaches 16 commits and wraps to 0
    rdWB = 6'd1; regWriteWB = 1;
    for (int i = 0; i < 14; i++) begin
      AluResultsWB = 32'(i + 100);
      step();
    end
    regWriteWB = 0; rsID = 6'd1;
    #1 check_eq("wrap_hz", {28'b0, cnt_b}, 32'd0);
    check_eq("wrap_def", {16'b0, cnt_a}, 32'd17);
    check_eq("last_val", rs_b, 32'd113);

    // Mid-cycle reset while a write to r12 is in flight
    rsID = 6'd7; rtID = 6'd13; rdWB = 6'd12; AluResultsWB = 32'h1234; regWriteWB = 1;
    flagWriteWB = 0;
    #2 rst_n = 1'b0;
    #1 check_eq("rst_mid_rs", rs_a, 32'h0);
    check_eq("rst_mid_flags", {30'b0, z_a, n_a}, 32'h0);
    check_eq("rst_mid_cnt", {16'b0, cnt_a}, 32'h0);
    check_eq("rst_mid_cnt_hz", {28'b0, cnt_b}, 32'h0);
    step();
    regWriteWB = 0; rsID = 6'd12;
    #1 check_eq("rst_nowrite", rs_a, 32'h0);
    rst_n = 1'b1;
    rdWB = 6'd3; AluResultsWB = 32'hCAFE; regWriteWB = 1;
    step();
    regWriteWB = 0; rsID = 6'd3;
    #1 check_eq("post_rst_rs", rs_a, 32'hCAFE);
    check_eq("post_rst_cnt", {16'b0, cnt_a}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back end of the MEMWB pipeline register and the register-file/flag store read by the decode stage.
- Consumes the WB-stage bundle: regWrite, memToReg, zero, neg, memory data, ALU result and rd.
- Selects the write-back value, commits it to a 64x32 register file and latches the Z/N condition flags.
- Serves two combinational decode read ports with same-cycle WB bypass, and keeps a retired-write counter for debug.

Parameters:
- NUM_REGS, 64, register count; the address width is fixed at 6 bits.
- DATA_W, 32, register and datapath width.
- ZERO_HARDWIRED, 0, when 1, register 0 always reads 0 and writes to it are discarded.
- CNT_W, 16, width of the retired-write counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- regWriteWB  in  1  commit enable from MEMWB.
- memToRegWB  in  1  1 selects memDataOutWB; 0 selects AluResultsWB.
- zeroWB  in  1  zero flag produced by the instruction in WB.
- negWB  in  1  negative flag produced by the instruction in WB.
- flagWriteWB  in  1  update the Z/N flag register this cycle.
- memDataOutWB  in  32  load data.
- AluResultsWB  in  32  ALU result.
- rdWB  in  6  destination register.
- rsID  in  6  read address A (decode stage).
- rtID  in  6  read address B (decode stage).
- rsData  out  32  read data A.
- rtData  out  32  read data B.
- zeroFlag  out  1  architectural Z flag, with bypass.
- negFlag  out  1  architectural N flag, with bypass.
- wbData  out  32  selected write-back value, for forwarding to EX.
- wbCount  out  CNT_W  number of committed register writes.

Behaviour:
- Reset (rst_n low, asynchronous): all registers clear to 0; flags clear to 0; wbCount clears to 0.
- Reset takes effect immediately, mid-cycle, overriding any write in progress. The first write after release occurs on the first rising edge with rst_n high.
- wbData is combinational: memToRegWB ? memDataOutWB : AluResultsWB. It is valid regardless of regWriteWB.
- Register write: on a rising edge with regWriteWB=1, reg[rdWB] <= wbData.
- When ZERO_HARDWIRED=1 and rdWB=0, the register write is suppressed and wbCount does not increment.
- Reads are combinational. rsData = reg[rsID], except when regWriteWB=1, rsID=rdWB and the write is not suppressed; then rsData = wbData (write-first bypass). rtData follows the same rule.
- With ZERO_HARDWIRED=1, reading address 0 returns 0 regardless of any bypass.
- Both read ports may address the same register, or the register being written, in the same cycle. Both return identical bypassed data.
- Flags: on a rising edge with flagWriteWB=1, Z <= zeroWB and N <= negWB. With flagWriteWB=0 the flags hold.
- zeroFlag/negFlag are bypassed the same way: when flagWriteWB=1 they show zeroWB/negWB in the same cycle; otherwise they show the stored flags.
- Flag updates are independent of regWriteWB. Both may occur in the same cycle.
- wbCount increments by 1 on each committed register write. It wraps from 2^CNT_W-1 to 0 with no sticky overflow indication.
- Latency: register write to architectural state takes 1 edge. Bypass makes the new value visible to decode in the same cycle, so there is 0 effective read-after-write latency.
- X-safety: when regWriteWB=0, rdWB and the data inputs may be X without corrupting state or counters.

Test Plan:
- Reset: drive rst_n=0 mid-cycle after prior writes -> all reads immediately return 0; zeroFlag=0; negFlag=0; wbCount=0.
- ALU write-back: memToRegWB=0, AluResultsWB=0x0000_00A5, rdWB=7, regWriteWB=1 for 1 edge -> rsID=7 reads 0xA5; wbCount=1.
- Load write-back with bypass: memToRegWB=1, memDataOutWB=0xDEAD_BEEF, rdWB=12, and rsID=rtID=12 in the same cycle -> both ports show 0xDEADBEEF before the edge; reg[12]=0xDEADBEEF after it.
- Disabled write: regWriteWB=0, rdWB=7, AluResultsWB=0xFFFF_FFFF -> reg[7] stays 0xA5; wbCount unchanged; wbData still shows 0xFFFFFFFF.
- Flags: flagWriteWB=1 with zeroWB=1, negWB=0 -> zeroFlag=1 in the same cycle and held afterwards. Next, flagWriteWB=0 with zeroWB=0 -> zeroFlag stays 1.
- Hardwired zero and wrap: with ZERO_HARDWIRED=1, a write of 0x55 to rdWB=0 -> reads return 0 and wbCount is unchanged. With CNT_W=4, 16 committed writes -> wbCount returns to 0.
